// File: rtl/mux_key_with_default.sv
// Key-lookup multiplexer: compares key against a packed (key, data) table and returns the
// OR of matching data words, or default_out on a miss, plus a registered copy with hit flag.
module mux_key_with_default #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [KEY_LEN-1:0]                    key,
    input  logic [DATA_LEN-1:0]                   default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
    output logic [DATA_LEN-1:0]                   out,
    output logic                                  hit,
    output logic [DATA_LEN-1:0]                   out_q,
    output logic                                  hit_q
);

    localparam int PAIR = KEY_LEN + DATA_LEN;

    logic [DATA_LEN-1:0] or_data;
    logic                hit_d;
    logic [DATA_LEN-1:0] out_d;

    // Match is folded in with AND/OR rather than if, so unknown key bits propagate.
    always_comb begin
        hit_d   = 1'b0;
        or_data = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            logic match;
            match   = (lut[i*PAIR+DATA_LEN +: KEY_LEN] == key);
            hit_d   = hit_d | match;
            or_data = or_data | ({DATA_LEN{match}} & lut[i*PAIR +: DATA_LEN]);
        end
        out_d = hit_d ? or_data : default_out;
    end

    assign out = out_d;
    assign hit = hit_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            hit_q <= 1'b0;
        end else begin
            out_q <= out_d;
            hit_q <= hit_d;
        end
    end

endmodule

// File: tb/tb_mux_key_with_default.sv
// Bench for mux_key_with_default: directed table cases plus randomized lookups checked
// against an array-based reference model, including async reset and 1-cycle register lag.
module tb_mux_key_with_default;

    localparam int NA = 4;
    localparam int KA = 12;
    localparam int DA = 32;
    localparam int NB = 2;
    localparam int KB = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: CSR-style table (4,12,32)
    logic [KA-1:0]         key_a;
    logic [DA-1:0]         def_a;
    logic [NA*(KA+DA)-1:0] lut_a;
    logic [DA-1:0]         out_a, out_q_a;
    logic                  hit_a, hit_q_a;

    // Instance B: duplicate-key table (2,4,8)
    logic [KB-1:0]         key_b;
    logic [DB-1:0]         def_b;
    logic [NB*(KB+DB)-1:0] lut_b;
    logic [DB-1:0]         out_b, out_q_b;
    logic                  hit_b, hit_q_b;

    mux_key_with_default #(.NR_KEY(NA), .KEY_LEN(KA), .DATA_LEN(DA)) u_dut_a (
        .clk(clk), .rst(rst), .key(key_a), .default_out(def_a), .lut(lut_a),
        .out(out_a), .hit(hit_a), .out_q(out_q_a), .hit_q(hit_q_a)
    );

    mux_key_with_default #(.NR_KEY(NB), .KEY_LEN(KB), .DATA_LEN(DB)) u_dut_b (
        .clk(clk), .rst(rst), .key(key_b), .default_out(def_b), .lut(lut_b),
        .out(out_b), .hit(hit_b), .out_q(out_q_b), .hit_q(hit_q_b)
    );

    // Table contents held as plain arrays; index 0 is the last-listed pair.
    logic [KA-1:0] keys_a [NA];
    logic [DA-1:0] data_a [NA];
    logic [KB-1:0] keys_b [NB];
    logic [DB-1:0] data_b [NB];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_a();
        for (int i = 0; i < NA; i++) lut_a[i*(KA+DA) +: (KA+DA)] = {keys_a[i], data_a[i]};
    endtask

    task automatic pack_b();
        for (int i = 0; i < NB; i++) lut_b[i*(KB+DB) +: (KB+DB)] = {keys_b[i], data_b[i]};
    endtask

    function automatic logic [DA-1:0] model_a(input logic [KA-1:0] k, input logic [DA-1:0] dflt,
                                              output logic h);
        logic [DA-1:0] acc;
        acc = '0;
        h   = 1'b0;
        for (int i = 0; i < NA; i++) begin
            if (keys_a[i] == k) begin
                h   = 1'b1;
                acc = acc | data_a[i];
            end
        end
        return h ? acc : dflt;
    endfunction

    logic [DA-1:0] exp_out, exp_out_q;
    logic          exp_hit, exp_hit_q;

    initial begin
        // Table: {300,1800, 305,80000100, 341,80000040, 342,0000000B}
        keys_a[3] = 12'h300; data_a[3] = 32'h0000_1800;
        keys_a[2] = 12'h305; data_a[2] = 32'h8000_0100;
        keys_a[1] = 12'h341; data_a[1] = 32'h8000_0040;
        keys_a[0] = 12'h342; data_a[0] = 32'h0000_000B;
        pack_a();
        def_a = '0;
        key_a = 12'h305;
        keys_b[1] = 4'h3; data_b[1] = 8'h0F;
        keys_b[0] = 4'h3; data_b[0] = 8'hF0;
        pack_b();
        def_b = 8'h5A;
        key_b = 4'h3;

        #1;
        check("rst_out_q", 64'(out_q_a), 64'h0);
        check("rst_hit_q", 64'(hit_q_a), 64'h0);
        check("k305_out", 64'(out_a), 64'h8000_0100);
        check("k305_hit", 64'(hit_a), 64'h1);
        key_a = 12'h342; #1;
        check("k342_out", 64'(out_a), 64'hB);
        key_a = 12'h300; #1;
        check("k300_out", 64'(out_a), 64'h1800);
        key_a = 12'h344; #1;
        check("miss_def0_out", 64'(out_a), 64'h0);
        check("miss_hit", 64'(hit_a), 64'h0);
        def_a = 32'hDEAD_BEEF; #1;
        check("miss_defbeef_out", 64'(out_a), 64'hDEAD_BEEF);
        check("dup_out", 64'(out_b), 64'hFF);
        check("dup_hit", 64'(hit_b), 64'h1);
        key_b = 4'h0; #1;
        check("b_miss_out", 64'(out_b), 64'h5A);
        check("b_miss_hit", 64'(hit_b), 64'h0);
        check("rst_held_out_q", 64'(out_q_a), 64'h0);

        // Registered path
        @(negedge clk);
        rst = 1'b0;
        def_a = '0;
        key_a = 12'h300;
        @(posedge clk); #1;
        check("reg1_out_q", 64'(out_q_a), 64'h1800);
        check("reg1_hit_q", 64'(hit_q_a), 64'h1);
        key_a = 12'h341; #1;
        check("lag_out", 64'(out_a), 64'h8000_0040);
        check("lag_out_q", 64'(out_q_a), 64'h1800);
        @(posedge clk); #1;
        check("reg2_out_q", 64'(out_q_a), 64'h8000_0040);
        check("reg2_hit_q", 64'(hit_q_a), 64'h1);
        key_a = 12'h344; def_a = 32'h1111_2222;
        @(posedge clk); #1;
        check("reg_miss_hit_q", 64'(hit_q_a), 64'h0);
        check("reg_miss_out_q", 64'(out_q_a), 64'h1111_2222);

        // Async reset between edges
        key_a = 12'h300; def_a = '0;
        @(posedge clk); #1;
        check("pre_rst_out_q", 64'(out_q_a), 64'h1800);
        #2 rst = 1'b1;
        #1;
        check("async_out_q", 64'(out_q_a), 64'h0);
        check("async_hit_q", 64'(hit_q_a), 64'h0);
        check("async_comb_out", 64'(out_a), 64'h1800);
        check("async_comb_hit", 64'(hit_a), 64'h1);
        #2 rst = 1'b0;
        #1;
        check("post_deassert_out_q", 64'(out_q_a), 64'h0);
        @(posedge clk); #1;
        check("first_cap_out_q", 64'(out_q_a), 64'h1800);
        check("first_cap_hit_q", 64'(hit_q_a), 64'h1);

        // Table data change with key held
        key_a = 12'h341;
        @(posedge clk); #1;
        check("pre_upd_out_q", 64'(out_q_a), 64'h8000_0040);
        data_a[1] = 32'h1234_5678;
        pack_a();
        #1;
        check("upd_out", 64'(out_a), 64'h1234_5678);
        check("upd_out_q_lag", 64'(out_q_a), 64'h8000_0040);
        @(posedge clk); #1;
        check("upd_out_q", 64'(out_q_a), 64'h1234_5678);

        // Randomized lookups, duplicate keys likely, occasional reset pulses
        exp_out_q = model_a(key_a, def_a, exp_hit_q);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            check("rnd_out_q", 64'(out_q_a), 64'(exp_out_q));
            check("rnd_hit_q", 64'(hit_q_a), 64'(exp_hit_q));
            rst = 1'b0;
            for (int i = 0; i < NA; i++) begin
                keys_a[i] = ($urandom_range(0, 3) == 0) ? KA'($urandom) : KA'($urandom_range(0, 7));
                data_a[i] = $urandom;
            end
            pack_a();
            def_a = $urandom;
            if ($urandom_range(0, 1) == 0) key_a = keys_a[$urandom_range(0, NA-1)];
            else                           key_a = KA'($urandom_range(0, 15));
            #1;
            exp_out = model_a(key_a, def_a, exp_hit);
            check("rnd_out", 64'(out_a), 64'(exp_out));
            check("rnd_hit", 64'(hit_a), 64'(exp_hit));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                #1;
                check("rnd_async_out_q", 64'(out_q_a), 64'h0);
                exp_out_q = '0;
                exp_hit_q = 1'b0;
            end else begin
                exp_out_q = exp_out;
                exp_hit_q = exp_hit;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
